// File: rtl/wb_burst_master_pkg.sv
// Shared definitions for the Wishbone burst initiator.
// Holds the FSM state encoding, the address step between beats, the
// width of beat counters and a helper that turns a burst length field
// (beats-1) into a beat count.
package wb_burst_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUS   = 2'd1,
        ST_DONE  = 2'd2,
        ST_ABORT = 2'd3
    } state_t;

    localparam logic [31:0] WB_WORD_STRIDE = 32'd4;
    localparam int          BEAT_W         = 5;

    // len is beats-1, so 0 -> 1 beat and 15 -> 16 beats.
    function automatic logic [BEAT_W-1:0] beats_from_len(input logic [3:0] len);
        return {1'b0, len} + 5'd1;
    endfunction

endpackage

// File: rtl/wb_watchdog.sv
// Idle-cycle watchdog for a Wishbone burst.
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   clear     - restart the idle count (progress was made this cycle)
//   enable    - count this cycle as idle when not cleared
//   expired   - combinational, high on the TIMEOUT_CYCLES-th consecutive
//               idle cycle so the owner can leave its busy state next edge
module wb_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [7:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_reg <= 8'd0;
        end else if (enable) begin
            count_reg <= count_reg + 8'd1;
        end
    end

    // count_reg holds the number of idle cycles already seen, so the
    // current idle cycle is the last one allowed when it equals TIMEOUT-1.
    assign expired = enable && !clear && (count_reg == 8'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/wb_burst_master.sv
// Wishbone pipelined burst initiator.
// Accepts a command (start address, direction, byte select, beats-1) and
// issues incrementing-address beats, pulling write data from a valid/ready
// stream and pushing read data out as one-cycle pulses. A watchdog aborts
// the burst if neither an issue nor an ack happens for TIMEOUT_CYCLES.
// Ports:
//   cmd_*        command handshake and fields
//   wr_*         write data stream (consumed exactly when a beat issues)
//   rd_*         read data pulses, one per read ack, no backpressure
//   resp_*       one-cycle burst completion report
//   o_wb_*/i_wb_* Wishbone pipelined master signals
module wb_burst_master
    import wb_burst_master_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_addr,
    input  logic [3:0]  cmd_sel,
    input  logic [3:0]  cmd_len,
    input  logic [31:0] wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [4:0]  resp_beats,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [3:0]  o_wb_sel,
    output logic [31:0] o_wb_addr,
    output logic [31:0] o_wb_data,
    input  logic [31:0] i_wb_data,
    input  logic        i_wb_ack,
    input  logic        i_wb_stall
);

    state_t              state_reg, state_next;
    logic [31:0]         addr_reg;
    logic                we_reg;
    logic [3:0]          sel_reg;
    logic [BEAT_W-1:0]   beats_reg;
    logic [BEAT_W-1:0]   issued_reg;
    logic [BEAT_W-1:0]   acks_reg;
    logic [3:0]          outstanding_reg;
    logic [31:0]         rd_data_reg;
    logic                rd_valid_reg;

    logic                issue;
    logic                ack_ok;
    logic                wd_clear;
    logic                wd_enable;
    logic                wd_expired;

    always_comb begin
        state_next = state_reg;
        cmd_ready  = 1'b0;
        o_wb_cyc   = 1'b0;
        o_wb_stb   = 1'b0;
        issue      = 1'b0;
        ack_ok     = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_beats = 5'd0;
        case (state_reg)
            ST_IDLE: begin
                // Held low while reset is asserted so no command is taken
                // on the reset edge.
                cmd_ready = !rst;
                if (cmd_valid && !rst) begin
                    state_next = ST_BUS;
                end
            end
            ST_BUS: begin
                o_wb_cyc = 1'b1;
                o_wb_stb = (issued_reg < beats_reg)
                        && (outstanding_reg < 4'(MAX_OUTSTANDING))
                        && (!we_reg || wr_valid);
                issue    = o_wb_stb && !i_wb_stall;
                // An ack with nothing in flight is a slave glitch; drop it.
                ack_ok   = i_wb_ack && (outstanding_reg != 4'd0);
                if (ack_ok && ((acks_reg + 5'd1) == beats_reg)) begin
                    state_next = ST_DONE;
                end else if (wd_expired) begin
                    state_next = ST_ABORT;
                end
            end
            ST_DONE: begin
                resp_valid = 1'b1;
                resp_beats = beats_reg;
                state_next = ST_IDLE;
            end
            ST_ABORT: begin
                resp_valid = 1'b1;
                resp_err   = 1'b1;
                resp_beats = acks_reg;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            addr_reg        <= 32'd0;
            we_reg          <= 1'b0;
            sel_reg         <= 4'd0;
            beats_reg       <= '0;
            issued_reg      <= '0;
            acks_reg        <= '0;
            outstanding_reg <= 4'd0;
            rd_data_reg     <= 32'd0;
            rd_valid_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            rd_valid_reg <= ack_ok && !we_reg;
            if (ack_ok && !we_reg) begin
                rd_data_reg <= i_wb_data;
            end
            if (cmd_ready && cmd_valid) begin
                addr_reg        <= cmd_addr;
                we_reg          <= cmd_we;
                sel_reg         <= cmd_sel;
                beats_reg       <= beats_from_len(cmd_len);
                issued_reg      <= '0;
                acks_reg        <= '0;
                outstanding_reg <= 4'd0;
            end
            if (issue) begin
                addr_reg   <= addr_reg + WB_WORD_STRIDE;
                issued_reg <= issued_reg + 5'd1;
            end
            if (ack_ok) begin
                acks_reg <= acks_reg + 5'd1;
            end
            case ({issue, ack_ok})
                2'b10:   outstanding_reg <= outstanding_reg + 4'd1;
                2'b01:   outstanding_reg <= outstanding_reg - 4'd1;
                default: outstanding_reg <= outstanding_reg;
            endcase
        end
    end

    assign wd_enable = (state_reg == ST_BUS);
    assign wd_clear  = !wd_enable || issue || ack_ok;

    wb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    // Gated by reset so a beat offered on the reset edge is not consumed.
    assign wr_ready  = we_reg && issue && !rst;
    assign o_wb_we   = o_wb_cyc && we_reg;
    assign o_wb_sel  = sel_reg;
    assign o_wb_addr = addr_reg;
    assign o_wb_data = wr_data;
    assign rd_data   = rd_data_reg;
    assign rd_valid  = rd_valid_reg;

endmodule

// File: tb/tb_wb_burst_master.sv
module tb_wb_burst_master;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_addr;
    logic [3:0]  cmd_sel;
    logic [3:0]  cmd_len;
    logic [31:0] wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        resp_valid;
    logic        resp_err;
    logic [4:0]  resp_beats;
    logic        o_wb_cyc;
    logic        o_wb_stb;
    logic        o_wb_we;
    logic [3:0]  o_wb_sel;
    logic [31:0] o_wb_addr;
    logic [31:0] o_wb_data;
    logic [31:0] i_wb_data;
    logic        i_wb_ack;
    logic        i_wb_stall;

    wb_burst_master #(
        .MAX_OUTSTANDING(2),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_we     (cmd_we),
        .cmd_addr   (cmd_addr),
        .cmd_sel    (cmd_sel),
        .cmd_len    (cmd_len),
        .wr_data    (wr_data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .resp_beats (resp_beats),
        .o_wb_cyc   (o_wb_cyc),
        .o_wb_stb   (o_wb_stb),
        .o_wb_we    (o_wb_we),
        .o_wb_sel   (o_wb_sel),
        .o_wb_addr  (o_wb_addr),
        .o_wb_data  (o_wb_data),
        .i_wb_data  (i_wb_data),
        .i_wb_ack   (i_wb_ack),
        .i_wb_stall (i_wb_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] data;
    } ack_t;

    int          pass_cnt = 0;
    int          chk_cnt  = 0;
    int          cyc_n    = 0;

    ack_t        ackq[$];
    logic [31:0] iss_addr[$];
    logic [31:0] iss_data[$];
    logic [3:0]  iss_sel[$];
    logic [31:0] rd_obs[$];
    logic [31:0] wr_tbl[16];
    int          wr_idx, wr_cnt;

    bit          rst_req, cmd_go, cmd_acc, ack_en;
    logic        go_we;
    logic [31:0] go_addr, cur_base;
    logic [3:0]  go_sel, go_len;
    int          ack_delay, force_ack_cyc, late_ack_off;
    int          stall_beat, stall_left, stall_seen, stall_bad;
    int          stb_cycles, out_model, out_max, wrr_bad;
    int          resp_cnt, resp_at, issue_at;
    logic        resp_err_l, resp_cyc_l;
    logic [4:0]  resp_beats_l;
    logic        last_cyc, last_stb, last_cmd_ready, last_wr_ready;
    logic        last_rd_valid, last_resp_valid;
    logic [31:0] last_addr;
    logic [3:0]  last_sel;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Slave read data is a fixed function of the beat address.
    function automatic logic [31:0] slave_word(input logic [31:0] addr);
        return 32'hDEADBEEF + (addr - 32'h100);
    endfunction

    // One clock cycle: drive inputs at the falling edge, sample 1 time unit
    // later, and update the bench model of what the next rising edge does.
    task automatic tick();
        ack_t a;
        @(negedge clk);
        cyc_n++;
        rst = rst_req;
        if (cmd_acc) begin
            cmd_valid = 1'b0;
            cmd_acc   = 1'b0;
        end
        if (cmd_go) begin
            cmd_valid = 1'b1;
            cmd_we    = go_we;
            cmd_addr  = go_addr;
            cmd_sel   = go_sel;
            cmd_len   = go_len;
            cmd_go    = 1'b0;
        end
        i_wb_ack  = 1'b0;
        i_wb_data = 32'd0;
        if (force_ack_cyc == cyc_n) begin
            i_wb_ack  = 1'b1;
            i_wb_data = 32'h0BAD0BAD;
        end else if (ack_en && ackq.size() > 0 && ackq[0].due <= cyc_n) begin
            i_wb_ack  = 1'b1;
            i_wb_data = ackq[0].data;
            void'(ackq.pop_front());
            out_model--;
        end
        i_wb_stall = (stall_left > 0) && (iss_addr.size() == stall_beat);
        wr_valid   = (wr_idx < wr_cnt);
        wr_data    = wr_valid ? wr_tbl[wr_idx] : 32'd0;
        #1;
        last_cyc        = o_wb_cyc;
        last_stb        = o_wb_stb;
        last_cmd_ready  = cmd_ready;
        last_wr_ready   = wr_ready;
        last_rd_valid   = rd_valid;
        last_resp_valid = resp_valid;
        last_addr       = o_wb_addr;
        last_sel        = o_wb_sel;
        if (rst) begin
            if (wr_ready) wrr_bad++;
        end else begin
            if (cmd_valid && cmd_ready) cmd_acc = 1'b1;
            if (o_wb_stb) stb_cycles++;
            if (o_wb_cyc && o_wb_stb && i_wb_stall) begin
                stall_left--;
                stall_seen++;
                if (wr_ready || o_wb_addr != cur_base + 32'(4 * iss_addr.size()))
                    stall_bad++;
            end
            if (o_wb_cyc && o_wb_stb && !i_wb_stall) begin
                iss_addr.push_back(o_wb_addr);
                iss_data.push_back(o_wb_data);
                iss_sel.push_back(o_wb_sel);
                if (o_wb_we) begin
                    if (!wr_ready) wrr_bad++;
                    wr_idx++;
                end
                a.due  = cyc_n + ack_delay;
                a.data = slave_word(o_wb_addr);
                ackq.push_back(a);
                out_model++;
                if (out_model > out_max) out_max = out_model;
                issue_at = cyc_n;
                if (late_ack_off > 0) force_ack_cyc = cyc_n + late_ack_off;
            end else if (wr_ready) begin
                wrr_bad++;
            end
            if (rd_valid) rd_obs.push_back(rd_data);
            if (resp_valid) begin
                resp_cnt++;
                resp_at      = cyc_n;
                resp_err_l   = resp_err;
                resp_beats_l = resp_beats;
                resp_cyc_l   = o_wb_cyc;
            end
        end
    endtask

    task automatic clear_model(input logic [31:0] base);
        ackq.delete();
        iss_addr.delete();
        iss_data.delete();
        iss_sel.delete();
        rd_obs.delete();
        cur_base      = base;
        resp_cnt      = 0;
        stall_beat    = 0;
        stall_left    = 0;
        stall_seen    = 0;
        stall_bad     = 0;
        stb_cycles    = 0;
        out_model     = 0;
        out_max       = 0;
        wrr_bad       = 0;
        wr_idx        = 0;
        wr_cnt        = 0;
        force_ack_cyc = -1;
        late_ack_off  = 0;
        ack_en        = 1'b1;
        ack_delay     = 1;
    endtask

    task automatic launch(input logic we, input logic [31:0] addr,
                          input logic [3:0] sel, input logic [3:0] len);
        go_we   = we;
        go_addr = addr;
        go_sel  = sel;
        go_len  = len;
        cmd_go  = 1'b1;
    endtask

    task automatic run_until_resp(input string tag, input int budget);
        for (int i = 0; i < budget && resp_cnt == 0; i++) tick();
        check({tag, "_resp_seen"}, 32'(resp_cnt), 32'd1);
        $display("txn %s: base=%08h issues=%0d reads=%0d resp_err=%0d resp_beats=%0d",
                 tag, cur_base, iss_addr.size(), rd_obs.size(), resp_err_l, resp_beats_l);
    endtask

    task automatic check_beats(input string tag, input int n, input bit is_write);
        check({tag, "_issues"}, 32'(iss_addr.size()), 32'(n));
        for (int i = 0; i < n && i < iss_addr.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), iss_addr[i], cur_base + 32'(4 * i));
            if (is_write)
                check($sformatf("%s_wdata%0d", tag, i), iss_data[i], wr_tbl[i]);
        end
    endtask

    task automatic check_reads(input string tag, input int n);
        check({tag, "_rd_count"}, 32'(rd_obs.size()), 32'(n));
        for (int i = 0; i < n && i < rd_obs.size(); i++)
            check($sformatf("%s_rdata%0d", tag, i), rd_obs[i], slave_word(cur_base + 32'(4 * i)));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        rst_req    = 1'b1;
        cmd_go     = 1'b0;
        cmd_acc    = 1'b0;
        cmd_valid  = 1'b0;
        cmd_we     = 1'b0;
        cmd_addr   = 32'd0;
        cmd_sel    = 4'd0;
        cmd_len    = 4'd0;
        wr_data    = 32'd0;
        wr_valid   = 1'b0;
        i_wb_data  = 32'd0;
        i_wb_ack   = 1'b0;
        i_wb_stall = 1'b0;
        clear_model(32'd0);

        // Reset state
        tick();
        tick();
        check("rst_cyc", 32'(last_cyc), 32'd0);
        check("rst_stb", 32'(last_stb), 32'd0);
        check("rst_cmd_ready", 32'(last_cmd_ready), 32'd0);
        check("rst_wr_ready", 32'(last_wr_ready), 32'd0);
        check("rst_rd_valid", 32'(last_rd_valid), 32'd0);
        check("rst_resp_valid", 32'(last_resp_valid), 32'd0);
        check("rst_addr", last_addr, 32'd0);
        check("rst_sel", 32'(last_sel), 32'd0);
        rst_req = 1'b0;
        tick();
        check("idle_cmd_ready", 32'(last_cmd_ready), 32'd1);

        // Single write beat, ack one cycle after issue
        clear_model(32'h0000_0010);
        wr_tbl[0] = 32'hA5A5_0001;
        wr_cnt    = 1;
        launch(1'b1, 32'h0000_0010, 4'hF, 4'd0);
        run_until_resp("wr1", 30);
        check_beats("wr1", 1, 1'b1);
        check("wr1_sel", 32'(iss_sel.size() > 0 ? iss_sel[0] : 4'h0), 32'hF);
        check("wr1_stb_cycles", 32'(stb_cycles), 32'd1);
        check("wr1_err", 32'(resp_err_l), 32'd0);
        check("wr1_beats", 32'(resp_beats_l), 32'd1);
        check("wr1_wr_ready_bad", 32'(wrr_bad), 32'd0);
        check("wr1_rd_count", 32'(rd_obs.size()), 32'd0);
        tick();

        // Read burst of 4, acks two cycles after each beat, plus a stray
        // ack in the first bus cycle while nothing is outstanding
        clear_model(32'h0000_0100);
        ack_delay     = 2;
        force_ack_cyc = cyc_n + 2;
        launch(1'b0, 32'h0000_0100, 4'hF, 4'd3);
        run_until_resp("rd4", 60);
        check_beats("rd4", 4, 1'b0);
        check_reads("rd4", 4);
        check("rd4_err", 32'(resp_err_l), 32'd0);
        check("rd4_beats", 32'(resp_beats_l), 32'd4);
        tick();

        // Write burst of 4 with the third beat stalled for 3 cycles
        clear_model(32'h0000_0200);
        for (int i = 0; i < 4; i++) wr_tbl[i] = 32'hC0DE_0000 | 32'(i);
        wr_cnt     = 4;
        stall_beat = 2;
        stall_left = 3;
        launch(1'b1, 32'h0000_0200, 4'h3, 4'd3);
        run_until_resp("stall", 60);
        check_beats("stall", 4, 1'b1);
        check("stall_sel", 32'(iss_sel.size() > 3 ? iss_sel[3] : 4'h0), 32'h3);
        check("stall_cycles", 32'(stall_seen), 32'd3);
        check("stall_held_bad", 32'(stall_bad), 32'd0);
        check("stall_wr_ready_bad", 32'(wrr_bad), 32'd0);
        check("stall_consumed", 32'(wr_idx), 32'd4);
        check("stall_beats", 32'(resp_beats_l), 32'd4);
        tick();

        // Outstanding cap of 2: withhold acks, then release them
        clear_model(32'h0000_0300);
        ack_en = 1'b0;
        launch(1'b0, 32'h0000_0300, 4'hF, 4'd7);
        for (int i = 0; i < 5; i++) tick();
        check("cap_issues_held", 32'(iss_addr.size()), 32'd2);
        check("cap_stb_low", 32'(last_stb), 32'd0);
        check("cap_cyc_high", 32'(last_cyc), 32'd1);
        ack_en = 1'b1;
        run_until_resp("cap", 80);
        check_beats("cap", 8, 1'b0);
        check_reads("cap", 8);
        check("cap_out_max", 32'(out_max), 32'd2);
        check("cap_beats", 32'(resp_beats_l), 32'd8);
        tick();

        // Watchdog abort on an unacked read at the top of the address space
        clear_model(32'hFFFF_FFFC);
        ack_en       = 1'b0;
        late_ack_off = 9;
        launch(1'b0, 32'hFFFF_FFFC, 4'hF, 4'd0);
        run_until_resp("tmo", 40);
        check_beats("tmo", 1, 1'b0);
        check("tmo_latency", 32'(resp_at - issue_at), 32'd9);
        check("tmo_err", 32'(resp_err_l), 32'd1);
        check("tmo_beats", 32'(resp_beats_l), 32'd0);
        check("tmo_cyc_at_resp", 32'(resp_cyc_l), 32'd0);
        for (int i = 0; i < 3; i++) tick();
        check("tmo_late_ack_rd", 32'(rd_obs.size()), 32'd0);
        check("tmo_single_resp", 32'(resp_cnt), 32'd1);
        check("tmo_back_idle", 32'(last_cmd_ready), 32'd1);

        // Reset in the middle of a 16-beat write
        clear_model(32'h0000_0400);
        for (int i = 0; i < 16; i++) wr_tbl[i] = 32'h5000_0000 + 32'(i);
        wr_cnt = 16;
        launch(1'b1, 32'h0000_0400, 4'hF, 4'd15);
        for (int i = 0; i < 30 && iss_addr.size() < 3; i++) tick();
        check("mid_issues_before_rst", 32'(iss_addr.size()), 32'd3);
        rst_req = 1'b1;
        tick();
        check("mid_rst_wr_ready", 32'(last_wr_ready), 32'd0);
        tick();
        check("mid_cyc", 32'(last_cyc), 32'd0);
        check("mid_stb", 32'(last_stb), 32'd0);
        rst_req = 1'b0;
        tick();
        tick();
        check("mid_cmd_ready", 32'(last_cmd_ready), 32'd1);
        check("mid_no_resp", 32'(resp_cnt), 32'd0);
        check("mid_consumed", 32'(wr_idx), 32'd3);
        check("mid_wr_ready_bad", 32'(wrr_bad), 32'd0);
        check("mid_issues_total", 32'(iss_addr.size()), 32'd3);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
